// File: rtl/eth_tx_scheduler.sv
// Purpose : round-robin arbiter sharing one RGMII transmit FSM between the
//           memory-buffer source (ch0) and the LFSR test-traffic source (ch1).
// Latency : grant/start one cycle after a request is seen in IDLE.
// Backpressure: a request is held by the source until its o_done/o_err.
//           The transmitter's busy level is used to run one frame at a time.
//
// Ports:
//   i_eth_clk / i_rst        clock, synchronous active-high reset
//   i_enable                 permits new arbitration (in-flight frame unaffected)
//   i_req[1:0]               per-channel frame request
//   i_size_0 / i_size_1      per-channel payload size in bytes
//   i_gap_count              inter-frame gap, latched at grant
//   i_eth_busy               busy level from the transmit FSM
//   o_eth_tx_start           start level to the transmit FSM
//   o_eth_tx_size            clamped frame size to the transmit FSM
//   o_eth_tx_lfsr_enable     1 while channel 1 owns the transmitter
//   o_gap_count              latched gap value
//   o_gnt[1:0]               one-hot grant, held for the whole frame
//   o_done[1:0]              one-cycle completion pulse for the granted channel
//   o_err                    one-cycle pulse when busy never rose after start
//   o_busy                   high whenever the scheduler is not idle
//   o_frame_cnt_0/1          wrapping per-channel completed-frame counters
module eth_tx_scheduler #(
    parameter int unsigned START_MIN    = 2,
    parameter int unsigned BUSY_TIMEOUT = 16,
    parameter int unsigned COOLDOWN     = 3,
    parameter int unsigned MAX_SIZE     = 1500
) (
    input  logic        i_eth_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [1:0]  i_req,
    input  logic [15:0] i_size_0,
    input  logic [15:0] i_size_1,
    input  logic [7:0]  i_gap_count,
    input  logic        i_eth_busy,
    output logic        o_eth_tx_start,
    output logic [15:0] o_eth_tx_size,
    output logic        o_eth_tx_lfsr_enable,
    output logic [7:0]  o_gap_count,
    output logic [1:0]  o_gnt,
    output logic [1:0]  o_done,
    output logic        o_err,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt_0,
    output logic [15:0] o_frame_cnt_1
);

    // The shared counter measures time in the current state; it is cleared on
    // entry to START and COOLDOWN. Terminal values are "last cycle" indices,
    // so a state occupying N cycles compares against N-1.
    localparam logic [7:0]  START_LAST   = 8'(START_MIN - 1);
    localparam logic [7:0]  TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);
    localparam logic [7:0]  COOL_LAST    = 8'(COOLDOWN - 1);
    localparam logic [15:0] MAX_SIZE_W   = 16'(MAX_SIZE);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_COOLDOWN  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_seen_q, busy_seen_d;
    logic        rr_q, rr_d;
    logic        start_q, start_d;
    logic [15:0] size_q, size_d;
    logic        lfsr_q, lfsr_d;
    logic [7:0]  gap_q, gap_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [15:0] frame_cnt_0_q, frame_cnt_0_d;
    logic [15:0] frame_cnt_1_q, frame_cnt_1_d;

    // Arbitration and start-phase helpers
    logic        contend;
    logic        win_ch;
    logic [15:0] win_size;
    logic        busy_now;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        busy_seen_d   = busy_seen_q;
        rr_d          = rr_q;
        start_d       = start_q;
        size_d        = size_q;
        lfsr_d        = lfsr_q;
        gap_d         = gap_q;
        gnt_d         = gnt_q;
        done_d        = 2'b00;
        err_d         = 1'b0;
        frame_cnt_0_d = frame_cnt_0_q;
        frame_cnt_1_d = frame_cnt_1_q;

        // With a single requester it wins outright; on contention the
        // pointer decides, so the pointer only moves on a two-way race.
        contend  = i_req[0] & i_req[1];
        win_ch   = contend ? rr_q : i_req[1];
        win_size = win_ch ? i_size_1 : i_size_0;

        // Busy may rise on the very cycle we check, so fold the live sample
        // into the sticky flag before deciding.
        busy_now = busy_seen_q | i_eth_busy;

        case (state_q)
            S_IDLE: begin
                if (i_enable && (i_req != 2'b00)) begin
                    gnt_d       = win_ch ? 2'b10 : 2'b01;
                    start_d     = 1'b1;
                    // Only an upper clamp: the transmitter pads short frames.
                    size_d      = (win_size > MAX_SIZE_W) ? MAX_SIZE_W : win_size;
                    lfsr_d      = win_ch;
                    gap_d       = i_gap_count;
                    cnt_d       = 8'd0;
                    busy_seen_d = 1'b0;
                    if (contend) begin
                        rr_d = ~win_ch;
                    end
                    state_d     = S_START;
                end
            end

            S_START: begin
                busy_seen_d = busy_now;
                cnt_d       = cnt_q + 8'd1;
                if (busy_now && (cnt_q >= START_LAST)) begin
                    start_d = 1'b0;
                    state_d = S_WAIT_DONE;
                end else if (!busy_now && (cnt_q >= TIMEOUT_LAST)) begin
                    // Transmitter never acknowledged: abandon the frame
                    // without counting it.
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    gnt_d   = 2'b00;
                    cnt_d   = 8'd0;
                    state_d = S_COOLDOWN;
                end
            end

            S_WAIT_DONE: begin
                if (!i_eth_busy) begin
                    done_d = gnt_q;
                    if (gnt_q[0]) begin
                        frame_cnt_0_d = frame_cnt_0_q + 16'd1;
                    end
                    if (gnt_q[1]) begin
                        frame_cnt_1_d = frame_cnt_1_q + 16'd1;
                    end
                    gnt_d   = 2'b00;
                    cnt_d   = 8'd0;
                    state_d = S_COOLDOWN;
                end
            end

            S_COOLDOWN: begin
                // Keeps start low long enough for the transmitter's
                // three-flop start edge detector to see a clean low.
                cnt_d = cnt_q + 8'd1;
                if (cnt_q >= COOL_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_eth_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            busy_seen_q   <= 1'b0;
            rr_q          <= 1'b0;
            start_q       <= 1'b0;
            size_q        <= 16'd0;
            lfsr_q        <= 1'b0;
            gap_q         <= 8'd0;
            gnt_q         <= 2'b00;
            done_q        <= 2'b00;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            frame_cnt_0_q <= 16'd0;
            frame_cnt_1_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            busy_seen_q   <= busy_seen_d;
            rr_q          <= rr_d;
            start_q       <= start_d;
            size_q        <= size_d;
            lfsr_q        <= lfsr_d;
            gap_q         <= gap_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            frame_cnt_0_q <= frame_cnt_0_d;
            frame_cnt_1_q <= frame_cnt_1_d;
        end
    end

    assign o_eth_tx_start       = start_q;
    assign o_eth_tx_size        = size_q;
    assign o_eth_tx_lfsr_enable = lfsr_q;
    assign o_gap_count          = gap_q;
    assign o_gnt                = gnt_q;
    assign o_done               = done_q;
    assign o_err                = err_q;
    assign o_busy               = busy_q;
    assign o_frame_cnt_0        = frame_cnt_0_q;
    assign o_frame_cnt_1        = frame_cnt_1_q;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Purpose : scoreboard bench for eth_tx_scheduler with a reactive busy model.
// Latency : expected grants are queued at stimulus time, popped on start rise.
// Backpressure: busy model raises busy 3 cycles after start for 150 cycles.
module tb_eth_tx_scheduler;

    localparam int BUSY_LEN = 150;

    typedef struct {
        logic [1:0]  gnt;
        logic [15:0] size;
        logic        lfsr;
        logic [7:0]  gap;
    } exp_t;

    logic        i_eth_clk;
    logic        i_rst;
    logic        i_enable;
    logic [1:0]  i_req;
    logic [15:0] i_size_0;
    logic [15:0] i_size_1;
    logic [7:0]  i_gap_count;
    logic        i_eth_busy;
    logic        o_eth_tx_start;
    logic [15:0] o_eth_tx_size;
    logic        o_eth_tx_lfsr_enable;
    logic [7:0]  o_gap_count;
    logic [1:0]  o_gnt;
    logic [1:0]  o_done;
    logic        o_err;
    logic        o_busy;
    logic [15:0] o_frame_cnt_0;
    logic [15:0] o_frame_cnt_1;

    int   vec_cnt;
    int   miscmp_cnt;
    exp_t sb_q[$];
    logic busy_en;
    int   done0_tot;
    int   done1_tot;
    int   err_tot;

    eth_tx_scheduler dut (
        .i_eth_clk            (i_eth_clk),
        .i_rst                (i_rst),
        .i_enable             (i_enable),
        .i_req                (i_req),
        .i_size_0             (i_size_0),
        .i_size_1             (i_size_1),
        .i_gap_count          (i_gap_count),
        .i_eth_busy           (i_eth_busy),
        .o_eth_tx_start       (o_eth_tx_start),
        .o_eth_tx_size        (o_eth_tx_size),
        .o_eth_tx_lfsr_enable (o_eth_tx_lfsr_enable),
        .o_gap_count          (o_gap_count),
        .o_gnt                (o_gnt),
        .o_done               (o_done),
        .o_err                (o_err),
        .o_busy               (o_busy),
        .o_frame_cnt_0        (o_frame_cnt_0),
        .o_frame_cnt_1        (o_frame_cnt_1)
    );

    initial begin
        i_eth_clk = 1'b0;
        forever #5 i_eth_clk = ~i_eth_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec_cnt++;
        if (got !== want) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic [1:0] g, input logic [15:0] s, input logic l, input logic [7:0] gp);
        exp_t e;
        e.gnt  = g;
        e.size = s;
        e.lfsr = l;
        e.gap  = gp;
        sb_q.push_back(e);
    endtask

    task automatic wait_evt(input int budget, output logic [1:0] d, output logic e);
        logic hit;
        d   = 2'b00;
        e   = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < budget && !hit; n++) begin
            @(negedge i_eth_clk);
            if (o_done != 2'b00 || o_err) begin
                hit = 1'b1;
                d   = o_done;
                e   = o_err;
            end
        end
        chk("wait_evt_bound", hit, 1);
    endtask

    task automatic wait_rise(input int budget);
        logic hit;
        hit = 1'b0;
        for (int n = 0; n < budget && !hit; n++) begin
            @(negedge i_eth_clk);
            if (o_eth_tx_start) hit = 1'b1;
        end
        chk("wait_rise_bound", hit, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, o_eth_tx_start, 0);
        chk({tag, "_size"},  o_eth_tx_size, 0);
        chk({tag, "_lfsr"},  o_eth_tx_lfsr_enable, 0);
        chk({tag, "_gap"},   o_gap_count, 0);
        chk({tag, "_gnt"},   o_gnt, 0);
        chk({tag, "_done"},  o_done, 0);
        chk({tag, "_err"},   o_err, 0);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_cnt0"},  o_frame_cnt_0, 0);
        chk({tag, "_cnt1"},  o_frame_cnt_1, 0);
    endtask

    // Busy model: busy goes high 3 cycles into start and stays for BUSY_LEN.
    initial begin
        i_eth_busy = 1'b0;
        forever begin
            @(negedge i_eth_clk);
            if (busy_en && o_eth_tx_start) begin
                repeat (2) @(negedge i_eth_clk);
                i_eth_busy = 1'b1;
                repeat (BUSY_LEN) @(negedge i_eth_clk);
                i_eth_busy = 1'b0;
            end
        end
    end

    // Output monitor: scoreboard pop on start rise, invariants every cycle.
    initial begin
        logic prev_start;
        int   low_cnt;
        exp_t cur;
        prev_start = 1'b0;
        low_cnt    = 100;
        cur.gnt = 2'b00; cur.size = 16'd0; cur.lfsr = 1'b0; cur.gap = 8'd0;
        done0_tot = 0;
        done1_tot = 0;
        err_tot   = 0;
        forever begin
            @(negedge i_eth_clk);
            if (o_eth_tx_start && !prev_start) begin
                chk("sb_has_expect", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    cur = sb_q.pop_front();
                    chk("sb_gnt",  o_gnt, cur.gnt);
                    chk("sb_size", o_eth_tx_size, cur.size);
                    chk("sb_lfsr", o_eth_tx_lfsr_enable, cur.lfsr);
                    chk("sb_gap",  o_gap_count, cur.gap);
                    chk("start_low_ge4", low_cnt >= 4, 1);
                end
            end
            if (o_eth_tx_start) low_cnt = 0;
            else                low_cnt++;
            if (o_gnt != 2'b00) chk("gnt_onehot", $countones(o_gnt), 1);
            if (o_done != 2'b00 || o_err) chk("done_err_excl", (o_done != 2'b00) && o_err, 0);
            if (o_done != 2'b00) begin
                chk("done_onehot",   $countones(o_done), 1);
                chk("done_is_owner", o_done, cur.gnt);
                chk("stable_size",   o_eth_tx_size, cur.size);
                chk("stable_lfsr",   o_eth_tx_lfsr_enable, cur.lfsr);
                chk("stable_gap",    o_gap_count, cur.gap);
                done0_tot += int'(o_done[0]);
                done1_tot += int'(o_done[1]);
            end
            if (o_err) err_tot++;
            prev_start = o_eth_tx_start;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] d;
        logic       e;
        int         hc;
        int         lc;

        vec_cnt = 0;
        miscmp_cnt = 0;
        busy_en = 1'b1;
        i_rst = 1'b1;
        i_enable = 1'b0;
        i_req = 2'b00;
        i_size_0 = 16'd0;
        i_size_1 = 16'd0;
        i_gap_count = 8'd0;
        repeat (3) @(negedge i_eth_clk);
        chk_all_zero("rst");
        i_rst = 1'b0;
        @(negedge i_eth_clk);

        // Single ch0 frame, later input changes must not leak in.
        i_enable = 1'b1;
        i_req = 2'b01;
        i_size_0 = 16'd100;
        i_gap_count = 8'd12;
        push_exp(2'b01, 16'd100, 1'b0, 8'd12);
        @(negedge i_eth_clk);
        chk("t1_latency", o_eth_tx_start, 1);
        hc = 0;
        do begin
            hc++;
            @(negedge i_eth_clk);
        end while (o_eth_tx_start && hc < 64);
        chk("t1_start_hi", hc, 3);
        chk("t1_gnt_held", o_gnt, 2'b01);
        i_size_0 = 16'd999;
        i_gap_count = 8'd3;
        wait_evt(400, d, e);
        chk("t1_done", d, 2'b01);
        chk("t1_err", e, 0);
        chk("t1_cnt0", o_frame_cnt_0, 1);
        chk("t1_cnt1", o_frame_cnt_1, 0);
        chk("t1_gnt_clr", o_gnt, 0);
        i_req = 2'b00;
        @(negedge i_eth_clk);
        chk("t1_done_pulse", o_done, 0);

        // Both channels contending continuously; size clamp on ch1.
        i_rst = 1'b1;
        i_req = 2'b11;
        i_size_0 = 16'd40;
        i_size_1 = 16'd2000;
        i_gap_count = 8'd7;
        push_exp(2'b01, 16'd40,   1'b0, 8'd7);
        push_exp(2'b10, 16'd1500, 1'b1, 8'd7);
        push_exp(2'b01, 16'd40,   1'b0, 8'd7);
        push_exp(2'b10, 16'd1500, 1'b1, 8'd7);
        repeat (2) @(negedge i_eth_clk);
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_evt(400, d, e);
            chk("t2_done_order", d, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_err", e, 0);
        end
        i_req = 2'b00;
        chk("t2_cnt0", o_frame_cnt_0, 2);
        chk("t2_cnt1", o_frame_cnt_1, 2);

        // Busy never rises: timeout, error, re-grant after cooldown. Size 0.
        busy_en = 1'b0;
        @(negedge i_eth_clk);
        i_size_0 = 16'd0;
        i_gap_count = 8'd200;
        i_req = 2'b01;
        push_exp(2'b01, 16'd0, 1'b0, 8'd200);
        push_exp(2'b01, 16'd0, 1'b0, 8'd200);
        wait_rise(64);
        hc = 0;
        do begin
            hc++;
            @(negedge i_eth_clk);
        end while (o_eth_tx_start && hc < 64);
        chk("t3_start_hi", hc, 16);
        chk("t3_err", o_err, 1);
        chk("t3_gnt", o_gnt, 0);
        chk("t3_done", o_done, 0);
        lc = 0;
        do begin
            lc++;
            @(negedge i_eth_clk);
        end while (!o_eth_tx_start && lc < 64);
        chk("t3_regrant_gap", lc, 4);
        chk("t3_regrant_gnt", o_gnt, 2'b01);
        i_req = 2'b00;
        wait_evt(64, d, e);
        chk("t3_err2", e, 1);
        chk("t3_done2", d, 0);
        @(negedge i_eth_clk);
        chk("t3_err_pulse", o_err, 0);
        chk("t3_cnt0", o_frame_cnt_0, 2);

        // Counter wrap; enable gating only blocks arbitration.
        busy_en = 1'b1;
        force dut.frame_cnt_0_q = 16'hFFFF;
        @(negedge i_eth_clk);
        release dut.frame_cnt_0_q;
        @(negedge i_eth_clk);
        chk("t5_preload", o_frame_cnt_0, 16'hFFFF);
        i_enable = 1'b0;
        i_req = 2'b01;
        i_size_0 = 16'd1500;
        i_gap_count = 8'd1;
        repeat (6) @(negedge i_eth_clk);
        chk("t5_en_blk_start", o_eth_tx_start, 0);
        chk("t5_en_blk_busy", o_busy, 0);
        i_enable = 1'b1;
        push_exp(2'b01, 16'd1500, 1'b0, 8'd1);
        wait_rise(64);
        i_enable = 1'b0;
        wait_evt(400, d, e);
        chk("t5_done", d, 2'b01);
        chk("t5_wrap_cnt0", o_frame_cnt_0, 16'h0000);
        chk("t5_cnt1_keep", o_frame_cnt_1, 2);
        i_req = 2'b00;
        i_enable = 1'b1;

        // Reset while in WAIT_DONE aborts silently.
        @(negedge i_eth_clk);
        i_req = 2'b10;
        i_size_1 = 16'd60;
        i_gap_count = 8'd9;
        push_exp(2'b10, 16'd60, 1'b1, 8'd9);
        wait_rise(64);
        repeat (10) @(negedge i_eth_clk);
        chk("t4_in_wait_busy", o_busy, 1);
        chk("t4_in_wait_start", o_eth_tx_start, 0);
        chk("t4_in_wait_gnt", o_gnt, 2'b10);
        i_rst = 1'b1;
        i_req = 2'b00;
        @(negedge i_eth_clk);
        chk_all_zero("t4_rst");
        i_rst = 1'b0;
        lc = 0;
        while (i_eth_busy && lc < 400) begin
            lc++;
            @(negedge i_eth_clk);
        end
        repeat (4) @(negedge i_eth_clk);
        chk("t4_idle_after", o_busy, 0);

        chk("sb_leftover", sb_q.size(), 0);
        chk("tot_done0", done0_tot, 4);
        chk("tot_done1", done1_tot, 2);
        chk("tot_err", err_tot, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
